// File: rtl/pipe_latch_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// NOP payload on empty slots, synchronous flush and a saturating bubble counter.
module pipe_latch_skid #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // state    | meaning
    // ST_EMPTY | no payload held, out_data = NOP_VALUE
    // ST_ONE   | main entry holds the payload presented downstream
    // ST_TWO   | main and skid entries both held, in_ready low (SKID=1 only)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_fire, out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_nxt  = in_data;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_nxt = in_data;
                end else if (out_fire) begin
                    main_nxt  = NOP_VALUE;
                    state_nxt = ST_EMPTY;
                end else if (in_fire && (SKID != 0)) begin
                    skid_nxt  = in_data;
                    state_nxt = ST_TWO;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_nxt  = skid_q;
                    skid_nxt  = NOP_VALUE;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                main_nxt  = NOP_VALUE;
                skid_nxt  = NOP_VALUE;
            end
        endcase
        // Flush wipes held and incoming payloads; an out_fire this cycle was still consumed.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = NOP_VALUE;
            skid_nxt  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            main_q <= NOP_VALUE;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Registered ready: computed from the next state so it is exact, not conservative.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_q     <= NOP_VALUE;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_nxt;
                    in_ready_q <= (state_nxt != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q   = NOP_VALUE;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && !flush && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: a SKID=1 and a SKID=0 instance share stimulus and are
// checked against a queue-based reference model of the stage.
module tb_pipe_latch_skid;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, flush, cnt_clr;
    logic [7:0] in_data;

    logic       s1_in_ready, s1_out_valid;
    logic [7:0] s1_out_data;
    logic [1:0] s1_occ;
    logic [3:0] s1_bc;
    logic       s0_in_ready, s0_out_valid;
    logic [7:0] s0_out_data;
    logic [1:0] s0_occ;
    logic [3:0] s0_bc;

    int errors = 0;
    int checks = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];
    int         bc1, bc0;

    logic       e1_valid, e1_rdy, e0_valid, e0_rdy;
    logic [7:0] e1_data, e0_data;
    logic [1:0] e1_occ, e0_occ;

    always #5 clk = ~clk;

    pipe_latch_skid #(.DATA_W(8), .NOP_VALUE(8'h00), .SKID(1), .CNT_W(4)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data),
        .flush(flush), .cnt_clr(cnt_clr), .occupancy(s1_occ), .bubble_cnt(s1_bc)
    );

    pipe_latch_skid #(.DATA_W(8), .NOP_VALUE(8'hEE), .SKID(0), .CNT_W(4)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
        .flush(flush), .cnt_clr(cnt_clr), .occupancy(s0_occ), .bubble_cnt(s0_bc)
    );

    // Expected outputs derived from the queue contents and current inputs.
    task automatic model_outputs();
        e1_valid = (q1.size() != 0);
        e1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
        e1_occ   = 2'(q1.size());
        e1_rdy   = (q1.size() < 2);
        e0_valid = (q0.size() != 0);
        e0_data  = (q0.size() != 0) ? q0[0] : 8'hEE;
        e0_occ   = 2'(q0.size());
        e0_rdy   = (q0.size() == 0) || out_ready;
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        bc1 = 0;
        bc0 = 0;
    endtask

    // Apply one clock edge to the model using the inputs presented before it.
    task automatic model_edge();
        bit f1, o1, f0, o0;
        f1 = in_valid && (q1.size() < 2);
        o1 = out_ready && (q1.size() != 0);
        f0 = in_valid && ((q0.size() == 0) || out_ready);
        o0 = out_ready && (q0.size() != 0);
        if (cnt_clr) bc1 = 0;
        else if (out_ready && q1.size() == 0 && !flush && bc1 < 15) bc1++;
        if (cnt_clr) bc0 = 0;
        else if (out_ready && q0.size() == 0 && !flush && bc0 < 15) bc0++;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (o1) void'(q1.pop_front());
            if (f1) q1.push_back(in_data);
            if (o0) void'(q0.pop_front());
            if (f0) q0.push_back(in_data);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) tick();
        @(negedge clk);
        checks += 6;
        if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s1_valid: got %0b exp 0", s1_out_valid); end
        if (s1_out_data !== 8'h00) begin errors++; $display("FAIL reset_s1_data: got %0h exp 00", s1_out_data); end
        if (s1_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s1_ready: got %0b exp 1", s1_in_ready); end
        if (s1_occ !== 2'd0 || s1_bc !== 4'd0) begin errors++; $display("FAIL reset_s1_occ_bc: got %0d/%0d exp 0/0", s1_occ, s1_bc); end
        if (s0_out_data !== 8'hEE) begin errors++; $display("FAIL reset_s0_data: got %0h exp ee", s0_out_data); end
        if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s0_ready: got %0b exp 1", s0_in_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] stim[6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        logic [7:0] got[$];
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, stim[i], 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            model_outputs();
            if (s1_out_valid) got.push_back(s1_out_data);
            checks += 4;
            if (s1_out_valid !== e1_valid) begin errors++; $display("FAIL stream_s1_valid[%0d]: got %0b exp %0b", i, s1_out_valid, e1_valid); end
            if (s1_out_data !== e1_data) begin errors++; $display("FAIL stream_s1_data[%0d]: got %0h exp %0h", i, s1_out_data, e1_data); end
            if (s1_occ !== e1_occ || s1_occ > 2'd1) begin errors++; $display("FAIL stream_s1_occ[%0d]: got %0d exp %0d", i, s1_occ, e1_occ); end
            if (s0_out_data !== e0_data) begin errors++; $display("FAIL stream_s0_data[%0d]: got %0h exp %0h", i, s0_out_data, e0_data); end
            tick();
        end
        checks++;
        if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33)
            begin errors++; $display("FAIL stream_order: got %p exp 11 22 33", got); end
    endtask

    task automatic test_skid();
        logic [7:0] dat[7] = '{8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'h00, 8'h00};
        logic       val[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ord[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] got[$];
        for (int i = 0; i < 7; i++) begin
            drive(val[i], dat[i], ord[i], 1'b0, 1'b0);
            @(negedge clk);
            model_outputs();
            if (s1_out_valid && out_ready) got.push_back(s1_out_data);
            checks += 5;
            if (s1_out_valid !== e1_valid) begin errors++; $display("FAIL skid_s1_valid[%0d]: got %0b exp %0b", i, s1_out_valid, e1_valid); end
            if (s1_out_data !== e1_data) begin errors++; $display("FAIL skid_s1_data[%0d]: got %0h exp %0h", i, s1_out_data, e1_data); end
            if (s1_occ !== e1_occ) begin errors++; $display("FAIL skid_s1_occ[%0d]: got %0d exp %0d", i, s1_occ, e1_occ); end
            if (s1_in_ready !== e1_rdy) begin errors++; $display("FAIL skid_s1_ready[%0d]: got %0b exp %0b", i, s1_in_ready, e1_rdy); end
            if (s0_in_ready !== e0_rdy) begin errors++; $display("FAIL skid_s0_ready[%0d]: got %0b exp %0b", i, s0_in_ready, e0_rdy); end
            if (i == 2) begin
                checks++;
                if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0)
                    begin errors++; $display("FAIL skid_full: got occ=%0d rdy=%0b exp occ=2 rdy=0", s1_occ, s1_in_ready); end
            end
            tick();
        end
        checks++;
        if (got.size() != 3 || got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3)
            begin errors++; $display("FAIL skid_order: got %p exp a1 a2 a3", got); end
    endtask

    task automatic test_flush();
        bit seen_b3 = 1'b0;
        drive(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0); tick();
        @(negedge clk);
        checks++;
        if (s1_occ !== 2'd2) begin errors++; $display("FAIL flush_prefill: got occ=%0d exp 2", s1_occ); end
        drive(1'b1, 8'hB3, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks += 4;
        if (s1_occ !== 2'd0) begin errors++; $display("FAIL flush_s1_occ: got %0d exp 0", s1_occ); end
        if (s1_out_valid !== 1'b0) begin errors++; $display("FAIL flush_s1_valid: got %0b exp 0", s1_out_valid); end
        if (s1_out_data !== 8'h00) begin errors++; $display("FAIL flush_s1_data: got %0h exp 00", s1_out_data); end
        if (s0_out_data !== 8'hEE || s0_out_valid !== 1'b0) begin errors++; $display("FAIL flush_s0: got %0h/%0b exp ee/0", s0_out_data, s0_out_valid); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (s1_out_valid && s1_out_data == 8'hB3) seen_b3 = 1'b1;
            tick();
        end
        checks++;
        if (seen_b3 !== 1'b0) begin errors++; $display("FAIL flush_discard: got b3 seen=%0b exp 0", seen_b3); end
    endtask

    task automatic test_skid0();
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (s0_out_valid !== 1'b1 || s0_in_ready !== 1'b0)
            begin errors++; $display("FAIL skid0_stall: got valid=%0b rdy=%0b exp 1/0", s0_out_valid, s0_in_ready); end
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            model_outputs();
            checks += 3;
            if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL skid0_ready[%0d]: got %0b exp 1", i, s0_in_ready); end
            if (s0_occ !== e0_occ || s0_occ > 2'd1) begin errors++; $display("FAIL skid0_occ[%0d]: got %0d exp %0d", i, s0_occ, e0_occ); end
            if (s0_out_data !== e0_data) begin errors++; $display("FAIL skid0_data[%0d]: got %0h exp %0h", i, s0_out_data, e0_data); end
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_bubble();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        checks += 2;
        if (s1_bc !== 4'd15 || bc1 != 15) begin errors++; $display("FAIL bubble_sat_s1: got %0d exp 15 (model %0d)", s1_bc, bc1); end
        if (s0_bc !== 4'd15) begin errors++; $display("FAIL bubble_sat_s0: got %0d exp 15", s0_bc); end
        tick();
        @(negedge clk);
        checks++;
        if (s1_bc !== 4'd15) begin errors++; $display("FAIL bubble_hold: got %0d exp 15", s1_bc); end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (s1_bc !== 4'd0 || s0_bc !== 4'd0) begin errors++; $display("FAIL bubble_clr: got %0d/%0d exp 0/0", s1_bc, s0_bc); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            @(negedge clk);
            model_outputs();
            checks += 10;
            if (s1_out_valid !== e1_valid) begin errors++; $display("FAIL rand_s1_valid[%0d]: got %0b exp %0b", i, s1_out_valid, e1_valid); end
            if (s1_out_data !== e1_data) begin errors++; $display("FAIL rand_s1_data[%0d]: got %0h exp %0h", i, s1_out_data, e1_data); end
            if (s1_occ !== e1_occ) begin errors++; $display("FAIL rand_s1_occ[%0d]: got %0d exp %0d", i, s1_occ, e1_occ); end
            if (s1_in_ready !== e1_rdy) begin errors++; $display("FAIL rand_s1_ready[%0d]: got %0b exp %0b", i, s1_in_ready, e1_rdy); end
            if (s1_bc !== 4'(bc1)) begin errors++; $display("FAIL rand_s1_bubble[%0d]: got %0d exp %0d", i, s1_bc, bc1); end
            if (s0_out_valid !== e0_valid) begin errors++; $display("FAIL rand_s0_valid[%0d]: got %0b exp %0b", i, s0_out_valid, e0_valid); end
            if (s0_out_data !== e0_data) begin errors++; $display("FAIL rand_s0_data[%0d]: got %0h exp %0h", i, s0_out_data, e0_data); end
            if (s0_occ !== e0_occ) begin errors++; $display("FAIL rand_s0_occ[%0d]: got %0d exp %0d", i, s0_occ, e0_occ); end
            if (s0_in_ready !== e0_rdy) begin errors++; $display("FAIL rand_s0_ready[%0d]: got %0b exp %0b", i, s0_in_ready, e0_rdy); end
            if (s0_bc !== 4'(bc0)) begin errors++; $display("FAIL rand_s0_bubble[%0d]: got %0d exp %0d", i, s0_bc, bc0); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (s1_occ !== 2'd2) begin errors++; $display("FAIL areset_prefill: got occ=%0d exp 2", s1_occ); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks += 4;
        if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin errors++; $display("FAIL areset_s1_state: got valid=%0b occ=%0d exp 0/0", s1_out_valid, s1_occ); end
        if (s1_out_data !== 8'h00) begin errors++; $display("FAIL areset_s1_data: got %0h exp 00", s1_out_data); end
        if (s1_in_ready !== 1'b1 || s1_bc !== 4'd0) begin errors++; $display("FAIL areset_s1_rdy_bc: got %0b/%0d exp 1/0", s1_in_ready, s1_bc); end
        if (s0_out_data !== 8'hEE || s0_out_valid !== 1'b0) begin errors++; $display("FAIL areset_s0: got %0h/%0b exp ee/0", s0_out_data, s0_out_valid); end
        tick();
        rst = 1'b1;
        drive(1'b1, 8'hD7, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (s1_out_valid !== 1'b1 || s1_out_data !== 8'hD7) begin errors++; $display("FAIL areset_recover: got %0b/%0h exp 1/d7", s1_out_valid, s1_out_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_skid0();
        test_bubble();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_latch_skid.md
Name: pipe_latch_skid

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field stage latches between EX/MEM/WB.
- Carries an opaque DATA_W-bit payload using a valid/ready handshake in place of the global stall vector.
- Optional 2-entry skid buffer so in_ready is registered and breaks the backward ready path.
- Empty slots present a NOP payload; synchronous flush and a saturating bubble counter for performance statistics.

Parameters:
DATA_W, 32, payload width in bits (>=1)
NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data whenever the stage is empty
SKID, 1, 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, bubble counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a real payload
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  payload to next stage; NOP_VALUE when out_valid=0
flush  input  1  synchronous discard of all held and incoming payloads
cnt_clr  input  1  synchronous clear of bubble_cnt
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)
bubble_cnt  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_data is sampled only on in_fire. out_data is stable while out_valid=1 and out_ready=0.
- Reset (rst=0, asynchronous): out_valid=0, out_data=NOP_VALUE, skid entry=NOP_VALUE, occupancy=0, bubble_cnt=0. in_ready=1 when SKID=1; when SKID=0 it is 1 because out_valid=0. A reset mid-transfer drops all held payloads.
- Latency: 1 cycle from in_fire to out_valid.
- Throughput: one transfer per cycle when out_ready is held at 1.
- SKID=1 state machine (occupancy encodes the state); in_ready = (occupancy != 2) and is driven from a register.
  - EMPTY(0): in_fire -> main <= in_data, go to ONE.
  - ONE(1), in_fire & out_fire -> main <= in_data, stay ONE.
  - ONE(1), out_fire only -> main <= NOP_VALUE, go to EMPTY.
  - ONE(1), in_fire only -> skid <= in_data, go to TWO.
  - ONE(1), neither -> hold.
  - TWO(2): in_ready=0. out_fire -> main <= skid, skid <= NOP_VALUE, go to ONE. Otherwise hold. Ordering is FIFO: the main entry always leaves before the skid entry.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). States EMPTY and ONE only, with the same transitions as above minus TWO; the skid register is not instantiated.
- Flush (priority over every event except reset): next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE, skid=NOP_VALUE. A payload presented with in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts as consumed downstream. in_ready follows the normal rule during flush.
- Bubble counter:
  - Increments by 1 on each cycle with out_ready=1 & out_valid=0 & flush=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr forces 0 next cycle and wins over a simultaneous increment.
- out_data must equal NOP_VALUE in every cycle where out_valid=0, so downstream legacy logic sees a NOP (no write-enable) without decoding valid.
- All state updates occur on the rising clk edge only, apart from the asynchronous reset.

Test Plan:
1. Reset then stream: SKID=1, rst low 3 cycles -> out_valid=0, out_data=0, in_ready=1. Then send 0x11,0x22,0x33 back-to-back with out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 1,2,3 after each in_fire; occupancy stays 1.
2. Backpressure/skid: out_ready=0, send 0xA1 then 0xA2 -> occupancy=2, in_ready=0 next cycle, 0xA3 held off. Raise out_ready -> outputs 0xA1, 0xA2, then 0xA3 in order; no loss, no duplication.
3. Flush with full skid: occupancy=2 (0xB1,0xB2), assert flush with in_valid=1 and in_data=0xB3 -> next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE; 0xB3 never appears.
4. SKID=0 mode: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. With out_ready=1 and in_valid=1 every cycle -> full throughput, occupancy never exceeds 1.
5. Bubble counter: CNT_W=4, out_ready=1 and no input for 20 cycles -> bubble_cnt=15 and held. Assert cnt_clr together with a bubble cycle -> bubble_cnt=0.
6. Async reset mid-operation: occupancy=2, drive rst low between clock edges -> outputs reach reset values immediately, with no clk edge required.
